// File: rtl/program_counter_high.sv
// High byte of the program counter: PCHS select, carry-in increment from the low byte,
// and a one-cycle branch page-crossing fix-up (+1/-1) sequenced by a two-state FSM.
module program_counter_high (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pch_pch,
  input  logic       i_adh_pch,
  input  logic [7:0] i_adh,
  input  logic       i_i_pc,
  input  logic       i_pclc,
  input  logic       i_br_adj,
  input  logic       i_br_dir,
  output logic [7:0] o_pch,
  output logic       o_busy,
  output logic       o_wrap
);

  typedef enum logic {IDLE, ADJUST} state_e;

  state_e     state_q, state_d;
  logic [7:0] pch_q, pch_d;
  logic       dir_q, dir_d;
  logic       wrap_q, wrap_d;

  logic [7:0] pchSel;
  logic [8:0] incSum;
  logic [7:0] adjVal;
  logic       adjWrap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      pch_q   <= 8'h00;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pch_q   <= pch_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  // A request arriving while ADJUST is running is dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_br_adj) state_d = ADJUST;
      ADJUST:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q == ADJUST);
  end

  always_comb begin
    pchSel = 8'h00;
    if (i_pch_pch) begin
      pchSel = pch_q;
    end else if (i_adh_pch) begin
      pchSel = i_adh;
    end
    incSum  = {1'b0, pchSel} + {8'h00, (i_i_pc & i_pclc)};
    adjVal  = dir_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
    adjWrap = dir_q ? (pch_q == 8'h00) : (pch_q == 8'hFF);

    pch_d  = incSum[7:0];
    wrap_d = incSum[8];
    dir_d  = dir_q;
    if (state_q == ADJUST) begin
      pch_d  = adjVal;
      wrap_d = adjWrap;
    end else if (i_br_adj) begin
      dir_d = i_br_dir;
    end
  end

  assign o_pch  = pch_q;
  assign o_wrap = wrap_q;

endmodule

// File: doc/program_counter_high.md
PROGRAM_COUNTER_HIGH -- requirements
Module: program_counter_high

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port i_pch_pch, input, 1 bit: control; the PCH select takes the current PCH register.
REQ-004 SHALL have port i_adh_pch, input, 1 bit: control; the PCH select takes i_adh.
REQ-005 SHALL have port i_adh, input, 8 bits: ADH bus.
REQ-006 SHALL have port i_i_pc, input, 1 bit: increment enable; the same control that drives the low-byte increment.
REQ-007 SHALL have port i_pclc, input, 1 bit: carry out of the PC low-byte increment logic (combinational, same cycle).
REQ-008 SHALL have port i_br_adj, input, 1 bit: request for a branch page-crossing fix-up on PCH.
REQ-009 SHALL have port i_br_dir, input, 1 bit: fix-up direction; 0 = +1 (forward page cross), 1 = -1 (backward page cross).
REQ-010 SHALL have port o_pch, output, 8 bits: PCH register value.
REQ-011 SHALL have port o_busy, output, 1 bit: high while a fix-up cycle is executing.
REQ-012 SHALL have port o_wrap, output, 1 bit: registered one-cycle pulse when a PCH update wraps FF->00 or 00->FF.

Function
REQ-013 SHALL implement a select stage (PCHS) that chooses r_pch when i_pch_pch=1, else i_adh when i_adh_pch=1, else 8'h00; i_pch_pch SHALL take priority when both selects are high.
REQ-014 SHALL add 1 (mod 256) to the PCHS output when i_i_pc=1 and i_pclc=1; otherwise the value SHALL pass through unchanged.
REQ-015 SHALL load the PCH register with the increment-stage result on every clock edge while the FSM is in IDLE; there SHALL be no hold-without-select path, so a cycle with no select loads 8'h00.
REQ-016 SHALL implement an FSM with two states: IDLE and ADJUST.
REQ-017 SHALL, in IDLE with i_br_adj=1, load PCH normally (REQ-015) that cycle, latch i_br_dir, and move to ADJUST on the next edge.
REQ-018 SHALL, in ADJUST, load PCH with PCH+1 (latched dir=0) or PCH-1 (latched dir=1), mod 256, ignoring i_pch_pch, i_adh_pch, i_i_pc and i_pclc, then return to IDLE on the same edge.
REQ-019 SHALL drive o_busy=1 exactly while the FSM is in ADJUST (one cycle per request), combinationally from the state.
REQ-020 SHALL ignore i_br_adj asserted while in ADJUST; that request is dropped, not queued.
REQ-021 SHALL make back-to-back requests possible: if i_br_adj=1 in the IDLE cycle immediately after an ADJUST, that request is accepted.
REQ-022 SHALL register o_wrap=1 for the cycle following any PCH update where the increment (REQ-014) produced a carry out of bit 7, or the ADJUST stage wrapped FF->00 (+1) or 00->FF (-1); o_wrap SHALL be 0 otherwise, and an ADH load of 8'h00 SHALL NOT assert it.
REQ-023 SHALL provide a 1-cycle latency from the inputs to o_pch; o_pch SHALL equal the register, with no combinational path from the inputs.

Reset
REQ-024 SHALL, when i_reset=1 at a clock edge, set PCH=8'h00, FSM=IDLE, the latched direction to 0 and o_wrap=0, so that o_busy=0; reset SHALL override all other inputs.
REQ-025 SHALL, if reset arrives while in ADJUST, abort the fix-up: PCH becomes 8'h00 and no adjustment is applied afterwards.

Verification
REQ-026 SHALL be covered by this scenario: i_adh=8'h12, i_adh_pch=1, i_i_pc=0 for one cycle, then i_pch_pch=1, i_i_pc=1, i_pclc=1 for one cycle -> o_pch=8'h12, then 8'h13; o_wrap stays 0.
REQ-027 SHALL be covered by this scenario: PCH=8'hFF, i_pch_pch=1, i_i_pc=1, i_pclc=1 for one cycle -> o_pch=8'h00 and o_wrap=1 for exactly one cycle.
REQ-028 SHALL be covered by this scenario: PCH=8'h20 held with i_pch_pch=1, i_br_adj=1, i_br_dir=0 for one cycle -> next cycle o_busy=1 and o_pch=8'h20; the following cycle o_pch=8'h21 and o_busy=0.
REQ-029 SHALL be covered by this scenario: PCH=8'h00, fix-up with i_br_dir=1, i_adh_pch=1, i_adh=8'h55 asserted during ADJUST -> o_pch=8'hFF (i_adh ignored) and o_wrap=1.
REQ-030 SHALL be covered by this scenario: i_br_adj held high for 4 cycles from IDLE -> o_busy pattern is 0,1,0,1 with two adjustments applied.
REQ-031 SHALL be covered by this scenario: i_reset=1 asserted during ADJUST with PCH=8'h7F -> next cycle o_pch=8'h00, o_busy=0, o_wrap=0, and no later adjustment.
